// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and divider helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int DATA_BITS = 8;

  // Opcodes consumed by the downstream memory-access command engine.
  localparam logic [7:0] CMD_OP_READ  = 8'h0F;
  localparam logic [7:0] CMD_OP_WRITE = 8'hFF;

  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// rtl/uart_rx_deframer_if.sv - serial input and received-byte outputs of the deframer
interface uart_rx_deframer_if;

  logic       rx;
  logic [7:0] RX_data;
  logic       byte_done;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output RX_data,
    output byte_done,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  RX_data,
    input  byte_done,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one tick every DIV clocks
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == CW'(DIV - 1))) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // clear restarts the bit phase, so it must also suppress a coincident tick.
  assign tick = !clear && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - oversampling 8N1 UART receiver with framing-error detection
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV        = calc_div(CLK_FREQ, BAUD, OVERSAMPLE)
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_rx_deframer_if.master rx_if
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID_CNT  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST_CNT = SW'(OVERSAMPLE - 1);

  rx_state_t            state, state_next;
  logic                 sync1, rxs, rxs_prev;
  logic [SW-1:0]        sample_cnt, sample_cnt_next;
  logic [2:0]           bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shreg;
  logic [7:0]           rx_data_q;
  logic                 byte_done_q, frame_err_q;
  logic                 tick, tick_clear, shift_en, load_byte, set_err;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    sample_cnt_next = sample_cnt;
    bit_cnt_next    = bit_cnt;
    tick_clear      = 1'b0;
    shift_en        = 1'b0;
    load_byte       = 1'b0;
    set_err         = 1'b0;
    case (state)
      IDLE: begin
        if (rxs_prev && !rxs) begin
          tick_clear      = 1'b1;
          sample_cnt_next = '0;
          state_next      = START;
        end
      end
      START: begin
        if (tick) begin
          if (sample_cnt == MID_CNT) begin
            if (!rxs) begin
              sample_cnt_next = '0;
              bit_cnt_next    = '0;
              state_next      = DATA;
            end else begin
              state_next = IDLE;
            end
          end else begin
            sample_cnt_next = sample_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (sample_cnt == LAST_CNT) begin
            sample_cnt_next = '0;
            shift_en        = 1'b1;
            bit_cnt_next    = bit_cnt + 1'b1;
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              state_next = STOP;
            end
          end else begin
            sample_cnt_next = sample_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (sample_cnt == LAST_CNT) begin
            sample_cnt_next = '0;
            if (rxs) begin
              load_byte  = 1'b1;
              state_next = IDLE;
            end else begin
              set_err    = 1'b1;
              state_next = BREAK;
            end
          end else begin
            sample_cnt_next = sample_cnt + 1'b1;
          end
        end
      end
      BREAK: begin
        // A held-low line must go high before another start edge can be seen.
        if (rxs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1       <= 1'b1;
      rxs         <= 1'b1;
      rxs_prev    <= 1'b1;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_data_q   <= '0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1       <= rx_if.rx;
      rxs         <= sync1;
      rxs_prev    <= rxs;
      sample_cnt  <= sample_cnt_next;
      bit_cnt     <= bit_cnt_next;
      byte_done_q <= load_byte;
      frame_err_q <= set_err;
      if (shift_en) begin
        shreg <= {rxs, shreg[DATA_BITS-1:1]};
      end
      if (load_byte) begin
        rx_data_q <= shreg;
      end
    end
  end

  assign rx_if.RX_data   = rx_data_q;
  assign rx_if.byte_done = byte_done_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.busy      = (state != IDLE);

endmodule
